// File: rtl/window_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : window_fetch_ctrl
// Raster-scans the frame, fetches each 3x3 neighbourhood tap by tap and hands
// the assembled window downstream. Build option WINDOW_BORDER_CLAMP_EN: taps
// outside the image take the centre value instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
module window_fetch_ctrl #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [3:0]         sel,
    output logic               rd_en,
    input  logic [PIX_W-1:0]   rd_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] win_data,
    output logic [7:0]         win_x,
    output logic [6:0]         win_y
);
    localparam logic [7:0] c_x_last   = 8'(IMG_W - 1);
    localparam logic [6:0] c_y_last   = 7'(IMG_H - 1);
    localparam logic [3:0] c_last_tap = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PIX_W-1:0] r_taps [9];
    logic [8:0]       r_invalid;
    logic [3:0]       r_prev_sel;
    logic             r_prev_rd;
    logic             w_last_pix;
    logic [7:0]       w_x_nxt;
    logic [6:0]       w_y_nxt;
    logic [PIX_W-1:0] w_border;

    // A tap is outside when its column/row offset steps past an image edge.
    function automatic logic tap_in_image(input logic [7:0] cx, input logic [6:0] cy,
                                          input logic [3:0] k);
        logic left, right, up, down;
        left  = (k == 4'd0) || (k == 4'd3) || (k == 4'd6);
        right = (k == 4'd2) || (k == 4'd5) || (k == 4'd8);
        up    = (k < 4'd3);
        down  = (k > 4'd5);
        return !((left && cx == 8'd0) || (right && cx == c_x_last) ||
                 (up && cy == 7'd0)   || (down && cy == c_y_last));
    endfunction

    assign w_last_pix = (x == c_x_last) && (y == c_y_last);

    always_comb begin
        w_x_nxt = x + 8'd1;
        w_y_nxt = y;
        if (x == c_x_last) begin
            w_x_nxt = 8'd0;
            w_y_nxt = y + 7'd1;
        end
    end

`ifdef WINDOW_BORDER_CLAMP_EN
    assign w_border = r_taps[4];
`else
    assign w_border = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        win_valid   = (r_state == S_HOLD);
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (sel == c_last_tap) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_HOLD;
            S_HOLD:  if (win_ready) w_state_nxt = w_last_pix ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // rd_en is registered alongside the sel it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            sel        <= '0;
            rd_en      <= 1'b0;
            r_prev_sel <= '0;
            r_prev_rd  <= 1'b0;
        end else begin
            r_prev_rd  <= rd_en;
            r_prev_sel <= sel;
            rd_en      <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    x     <= '0;
                    y     <= '0;
                    sel   <= '0;
                    rd_en <= tap_in_image(8'd0, 7'd0, 4'd0);
                end
                S_FETCH: if (sel != c_last_tap) begin
                    sel   <= sel + 4'd1;
                    rd_en <= tap_in_image(x, y, sel + 4'd1);
                end
                S_HOLD: if (win_ready && !w_last_pix) begin
                    x     <= w_x_nxt;
                    y     <= w_y_nxt;
                    sel   <= '0;
                    rd_en <= tap_in_image(w_x_nxt, w_y_nxt, 4'd0);
                end
                default: ;
            endcase
        end
    end

    // Read data lands one cycle behind its strobe; border fill happens in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invalid <= '0;
            for (int k = 0; k < 9; k++) r_taps[k] <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (r_prev_rd && r_prev_sel == 4'(k)) r_taps[k] <= rd_data;
                if (r_state == S_FETCH && sel == 4'(k)) r_invalid[k] <= !rd_en;
                if (r_state == S_DRAIN && r_invalid[k]) r_taps[k] <= w_border;
            end
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign win_data[k*PIX_W +: PIX_W] = r_taps[k];
    end

    assign win_x = x;
    assign win_y = y;

endmodule
`default_nettype wire
